// File: rtl/fibo_bcd_display.sv
// Binary-to-BCD display stage for the Fibonacci calculator: a double-dabble engine
// started on the rising edge of done, feeding five 7-segment digit drivers.
module fibo_bcd_display #(
  parameter bit BLANK_LZ       = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] bin_in,
  input  logic        bin_valid,
  output logic        busy,
  output logic        conv_done,
  output logic [19:0] bcd_out,
  output logic [34:0] seg_out
);

  typedef enum logic {IDLE, CONVERT} state_t;

  state_t      state, state_next;
  logic        valid_q;
  logic        rise;
  logic [15:0] shift_q;
  logic [19:0] scratch_q;
  logic [3:0]  count_q;
  logic [19:0] scratch_adj;
  logic [19:0] scratch_next;
  logic [15:0] shift_next;
  logic        last_iter;
  logic [3:0]  digit;
  logic [6:0]  pattern;
  logic        any_nz;

  assign rise      = bin_valid & ~valid_q;
  assign last_iter = (count_q == 4'd15);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (rise)      state_next = CONVERT;
      CONVERT: if (last_iter) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == CONVERT);
  end

  // One double-dabble iteration: add 3 to digits >= 5, then shift the pair left.
  always_comb begin
    scratch_adj = scratch_q;
    for (int i = 0; i < 5; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5)
        scratch_adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
    end
    scratch_next = {scratch_adj[18:0], shift_q[15]};
    shift_next   = {shift_q[14:0], 1'b0};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q   <= 1'b0;
      shift_q   <= '0;
      scratch_q <= '0;
      count_q   <= '0;
      bcd_out   <= '0;
      conv_done <= 1'b0;
    end else begin
      valid_q   <= bin_valid;
      conv_done <= 1'b0;
      case (state)
        IDLE: begin
          if (rise) begin
            shift_q   <= bin_in;
            scratch_q <= '0;
            count_q   <= '0;
          end
        end
        CONVERT: begin
          shift_q   <= shift_next;
          scratch_q <= scratch_next;
          count_q   <= count_q + 4'd1;
          if (last_iter) begin
            bcd_out   <= scratch_next;
            conv_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Scan from the most significant digit so leading zeros can be blanked.
  always_comb begin
    seg_out = '0;
    digit   = '0;
    pattern = '0;
    any_nz  = 1'b0;
    for (int i = 4; i >= 0; i--) begin
      digit  = bcd_out[4*i +: 4];
      any_nz = any_nz | (digit != 4'd0);
      case (digit)
        4'd0:    pattern = 7'b0111111;
        4'd1:    pattern = 7'b0000110;
        4'd2:    pattern = 7'b1011011;
        4'd3:    pattern = 7'b1001111;
        4'd4:    pattern = 7'b1100110;
        4'd5:    pattern = 7'b1101101;
        4'd6:    pattern = 7'b1111101;
        4'd7:    pattern = 7'b0000111;
        4'd8:    pattern = 7'b1111111;
        4'd9:    pattern = 7'b1101111;
        default: pattern = 7'b0000000;
      endcase
      if (BLANK_LZ && (i != 0) && !any_nz)
        pattern = 7'b0000000;
      seg_out[7*i +: 7] = SEG_ACTIVE_LOW ? ~pattern : pattern;
    end
  end

endmodule

// File: tb/tb_fibo_bcd_display.sv
// Directed bench for fibo_bcd_display: expected BCD values are queued when a
// conversion is launched and popped when conv_done appears.
module tb_fibo_bcd_display;

  logic        clk;
  logic        reset_n;
  logic [15:0] bin_in;
  logic        bin_valid;
  logic        busy, busy_nb;
  logic        conv_done, conv_done_nb;
  logic [19:0] bcd_out, bcd_out_nb;
  logic [34:0] seg_out, seg_out_nb;

  int total = 0;
  int bad   = 0;
  logic [19:0] exp_q[$];

  fibo_bcd_display #(.BLANK_LZ(1'b1), .SEG_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .bin_in(bin_in), .bin_valid(bin_valid),
    .busy(busy), .conv_done(conv_done), .bcd_out(bcd_out), .seg_out(seg_out)
  );

  fibo_bcd_display #(.BLANK_LZ(1'b0), .SEG_ACTIVE_LOW(1'b1)) dut_nb (
    .clk(clk), .reset_n(reset_n), .bin_in(bin_in), .bin_valid(bin_valid),
    .busy(busy_nb), .conv_done(conv_done_nb), .bcd_out(bcd_out_nb), .seg_out(seg_out_nb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [19:0] to_bcd(input int v);
    logic [19:0] r;
    r = '0;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'((v / (10 ** i)) % 10);
    end
    return r;
  endfunction

  // Active-low reference patterns {g,f,e,d,c,b,a}.
  function automatic logic [34:0] exp_seg(input logic [19:0] bcd, input bit blank);
    logic [6:0] tbl [10];
    logic [34:0] r;
    bit lead;
    tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
            7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    r = '0;
    lead = 1'b1;
    for (int i = 4; i >= 0; i--) begin
      if (bcd[4*i +: 4] != 4'd0) lead = 1'b0;
      if (blank && i > 0 && lead) r[7*i +: 7] = 7'h7f;
      else                        r[7*i +: 7] = tbl[bcd[4*i +: 4]];
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [39:0] observed, input logic [39:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [15:0] v);
    bin_in    = v;
    bin_valid = 1'b1;
    exp_q.push_back(to_bcd(int'(v)));
  endtask

  // Waits for conv_done; optionally fires a second rise at edge E5 that must be ignored.
  task automatic checkOutput(input string tag, input bit glitch);
    int cyc = 0;
    int busy_cnt = 0;
    bit seen = 1'b0;
    logic [19:0] e;
    while (!seen && cyc < 60) begin
      tick();
      cyc++;
      if (busy) busy_cnt++;
      if (conv_done) seen = 1'b1;
      if (glitch && cyc == 4) bin_valid = 1'b0;
      if (glitch && cyc == 5) begin
        bin_in    = 16'd1111;
        bin_valid = 1'b1;
      end
    end
    check({tag, "_seen"}, 40'(seen), 40'd1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 20'hfffff;
    check({tag, "_latency"}, 40'(cyc), 40'd17);
    check({tag, "_busy_cycles"}, 40'(busy_cnt), 40'd16);
    check({tag, "_bcd"}, 40'(bcd_out), 40'(e));
    check({tag, "_seg"}, 40'(seg_out), 40'(exp_seg(e, 1'b1)));
    check({tag, "_seg_noblank"}, 40'(seg_out_nb), 40'(exp_seg(e, 1'b0)));
    tick();
    check({tag, "_pulse_once"}, 40'(conv_done), 40'd0);
    check({tag, "_busy_off"}, 40'(busy), 40'd0);
  endtask

  task automatic expectQuiet(input string tag, input int n);
    int pulses = 0;
    int busy_seen = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (conv_done) pulses++;
      if (busy) busy_seen++;
    end
    check({tag, "_pulses"}, 40'(pulses), 40'd0);
    check({tag, "_busy"}, 40'(busy_seen), 40'd0);
  endtask

  initial begin
    reset_n   = 1'b0;
    bin_in    = '0;
    bin_valid = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();

    check("rst_busy", 40'(busy), 40'd0);
    check("rst_done", 40'(conv_done), 40'd0);
    check("rst_bcd", 40'(bcd_out), 40'd0);
    check("rst_seg", 40'(seg_out), {5'd0, 7'h7f, 7'h7f, 7'h7f, 7'h7f, 7'b1000000});
    check("rst_seg_noblank", 40'(seg_out_nb), {5'd0, {5{7'b1000000}}});

    $display("[TB] 987");
    applyStimulus(16'd987);
    checkOutput("t987", 1'b0);
    check("t987_digits", 40'(seg_out),
          {5'd0, 7'h7f, 7'h7f, 7'b0010000, 7'b0000000, 7'b1111000});
    bin_valid = 1'b0;
    tick();

    $display("[TB] 65535");
    applyStimulus(16'd65535);
    checkOutput("t65535", 1'b0);
    check("t65535_bcd_const", 40'(bcd_out), 40'h65535);
    bin_valid = 1'b0;
    tick();

    $display("[TB] zero");
    applyStimulus(16'd0);
    checkOutput("tzero", 1'b0);
    check("tzero_units", 40'(seg_out[6:0]), 40'b1000000);

    $display("[TB] held level");
    expectQuiet("held", 100);
    bin_valid = 1'b0;
    tick();
    applyStimulus(16'd1597);
    checkOutput("t1597", 1'b0);
    bin_valid = 1'b0;
    tick();

    $display("[TB] rise while busy");
    applyStimulus(16'd4660);
    checkOutput("tglitch", 1'b1);
    expectQuiet("after_glitch", 20);
    bin_valid = 1'b0;
    tick();

    $display("[TB] reset mid-conversion");
    bin_in    = 16'd2000;
    bin_valid = 1'b1;
    repeat (9) tick();
    check("mid_busy_pre", 40'(busy), 40'd1);
    reset_n   = 1'b0;
    bin_valid = 1'b0;
    #1;
    check("mid_busy", 40'(busy), 40'd0);
    check("mid_done", 40'(conv_done), 40'd0);
    check("mid_bcd", 40'(bcd_out), 40'd0);
    tick();
    reset_n = 1'b1;
    tick();
    applyStimulus(16'd233);
    checkOutput("t233", 1'b0);
    check("t233_bcd_const", 40'(bcd_out), 40'h00233);

    check("queue_empty", 40'(exp_q.size()), 40'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fibo_bcd_display.md
Name: fibo_bcd_display

Overview:
- Downstream stage of the Fibonacci calculator; consumes its 16-bit result (fibo_out) and its completion flag (done).
- Converts the unsigned binary result to 5 packed BCD digits with a sequential shift-add-3 (double dabble) engine.
- Drives five 7-segment digit outputs for the board display, with optional leading-zero blanking.
- The calculator's done is a level that can stay high across runs, so conversion starts on its rising edge, not on its level.

Parameters:
- BLANK_LZ, 1, 1 = leading zero digits blanked (all segments off); units digit always shown.
- SEG_ACTIVE_LOW, 1, 1 = segment outputs active-low (lit segment = 0); 0 = active-high.

Ports:
- clk  input  1  single system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- bin_in  input  16  unsigned binary value; connects to fibo_out.
- bin_valid  input  1  result-ready level; connects to done; conversion starts on its 0->1 transition.
- busy  output  1  high while a conversion is in progress.
- conv_done  output  1  one-cycle pulse when bcd_out is updated.
- bcd_out  output  20  packed BCD; [3:0] units ... [19:16] ten-thousands.
- seg_out  output  35  digit i (i=0 units) on [7i+6:7i], bit order {g,f,e,d,c,b,a}.

Behaviour:
- Reset (async, reset_n low):
  - state=IDLE; busy=0; conv_done=0; bcd_out=0.
  - Edge-detect register=0, so a bin_valid already high on release counts as a rising edge.
  - Scratch registers and counter cleared.
- Edge detect:
  - valid_q registers bin_valid every cycle in all states.
  - rise = bin_valid & ~valid_q.
- States: IDLE, CONVERT.
- IDLE:
  - On an edge where rise=1: capture bin_in into the shift register; clear the 20-bit BCD scratch; count=0; busy<=1; state<=CONVERT. This edge is E0.
  - Otherwise hold. bcd_out keeps its last value.
- CONVERT, edges E1..E16, one iteration per edge:
  - Add 3 to every scratch digit >=5.
  - Then shift {scratch, shift reg} left by 1 and increment count.
  - On E16 (count==15 before the edge):
    - bcd_out <= final scratch; conv_done <= 1 for exactly one cycle.
    - busy <= 0; state <= IDLE.
- Latency: conv_done is high in the cycle after E16, i.e. 16 cycles after the capture edge. Throughput is one conversion per 17 cycles.
- A rise while busy is ignored and not queued. valid_q still tracks, so a level held high never retriggers.
- A rise on the same edge that conv_done is set (E16) is ignored; state is still CONVERT at that edge.
- Arithmetic:
  - Maximum input 65535 -> BCD 6_5_5_3_5; no overflow possible with 5 digits.
  - Digit adjust is 4-bit; an adjusted digit is at most 12 before the shift.
- Segment decode:
  - Combinational from bcd_out only; does not change during conversion.
  - Standard 0-9 patterns, e.g. 0=abcdef, 1=bc, 7=abc, 8=all.
  - Codes 10-15 cannot occur; they decode to all-off.
  - With BLANK_LZ=1, digit i>0 is blanked when it and all higher digits are zero.
  - Polarity per SEG_ACTIVE_LOW: the reset display is "0" in the units digit, others blank.
- Reset mid-conversion aborts immediately to reset values. There is no partial update of bcd_out.

Test Plan:
1. Reset released with bin_valid=0, then bin_in=987 and bin_valid rises -> busy high 16 cycles; conv_done pulse 16 cycles after capture; bcd_out=20'h00987; seg digits 0-2 show 7, 8, 9; digits 3-4 blank (all ones, active-low).
2. bin_in=65535 -> bcd_out=20'h65535; all five digits lit; exactly one conv_done pulse.
3. bin_in=0 -> bcd_out=0; units shows "0" (seg[6:0]=7'b1000000 active-low); others blank. Repeat with BLANK_LZ=0 -> all five show "0".
4. bin_valid held high for 100 cycles after one conversion -> no second conv_done. Drop to 0, bin_in=1597, raise again -> bcd_out=20'h01597.
5. bin_valid toggles 0->1 at cycle 5 after the capture edge with a new bin_in -> ignored; bcd_out reflects the original value; busy timing unchanged.
6. reset_n asserted at cycle 8 of a conversion -> busy, conv_done, bcd_out all 0 immediately. After release, a fresh rise converts correctly (bin_in=233 -> 20'h00233).
